aud_dsp: RTL and testbench



---
 rtl/aud_dsp_pkg.sv | 22 ++
 rtl/aud_dsp_if.sv | 15 +
 rtl/aud_dsp_interp.sv | 32 +++
 rtl/aud_dsp.sv | 186 ++++++++++++++++++
 tb/tb_aud_dsp.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/aud_dsp_pkg.sv
// aud_pkg: shared types and default widths for the aud_dsp playback block.
//   state_t : playback FSM states (encoding is visible on o_state)
//   mode_t  : speed mode latched at each DACLRCK tick
package aud_pkg;
    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_FETCH = 3'd2,
        S_CALC  = 3'd3,
        S_PAUSE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        FAST   = 2'd1,
        SLOW0  = 2'd2,
        SLOW1  = 2'd3
    } mode_t;
endpackage

// File: rtl/aud_dsp_if.sv
// aud_dsp_if: SRAM read bus between the playback processor and the SRAM.
//   addr  : word address (master drives)
//   rdata : read data, valid one cycle after addr (slave drives)
interface aud_dsp_if
    import aud_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdata;

    modport master (output addr, input rdata);
    modport slave  (input addr, output rdata);
endinterface

// File: rtl/aud_dsp_interp.sv
// aud_interp: combinational linear interpolation between two samples.
//   i_prev, i_cur : signed samples
//   i_k           : sub-step 0..N-1
//   i_n           : step count N (1..8)
//   o_y           : prev + ((cur - prev) * k) / N, truncating toward zero
module aud_interp
    import aud_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] i_prev,
    input  logic [DATA_W-1:0] i_cur,
    input  logic [2:0]        i_k,
    input  logic [3:0]        i_n,
    output logic [DATA_W-1:0] o_y
);
    localparam int W = 2 * DATA_W;

    logic signed [W-1:0] w_prev, w_cur, w_k, w_n, w_prod, w_quot, w_sum;

    always_comb begin
        w_prev = W'($signed(i_prev));
        w_cur  = W'($signed(i_cur));
        w_k    = {{(W-3){1'b0}}, i_k};
        // N is never 0 in use; guard keeps the divider X-free while idle
        w_n    = (i_n == 4'd0) ? W'(1) : {{(W-4){1'b0}}, i_n};
        w_prod = (w_cur - w_prev) * w_k;
        w_quot = w_prod / w_n;
        w_sum  = w_prev + w_quot;
        o_y    = w_sum[DATA_W-1:0];
    end
endmodule

// File: rtl/aud_dsp.sv
// aud_dsp: playback sample processor. Reads one recorded sample per DACLRCK
// frame from SRAM and applies normal / fast (address skip) / slow (hold or
// linear interpolation) speed modes.
//   i_clk, i_rst         : BCLK, synchronous active-high reset
//   i_start/pause/stop   : transport commands (stop > pause > start > tick)
//   i_fast/slow_0/slow_1 : mode select, i_speed gives N = i_speed + 1
//   i_daclrck            : frame clock; rising edge is the processing tick
//   i_end_addr           : last recorded address (inclusive)
//   sram                 : SRAM read bus (master)
//   o_dac_data, o_en     : sample and enable for the DAC serializer
//   o_finish             : one-cycle pulse when playback ran past the end
//   o_state              : FSM state for debug LEDs
// Build option: AUD_DSP_LINEAR_INTERP_EN enables linear interpolation for
// i_slow_1; without it i_slow_1 behaves as i_slow_0.
module aud_dsp
    import aud_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_fast,
    input  logic              i_slow_0,
    input  logic              i_slow_1,
    input  logic [2:0]        i_speed,
    input  logic              i_daclrck,
    input  logic [ADDR_W-1:0] i_end_addr,
    aud_dsp_if.master         sram,
    output logic [DATA_W-1:0] o_dac_data,
    output logic              o_en,
    output logic              o_finish,
    output logic [2:0]        o_state
);
    state_t            r_state, w_next;
    mode_t             r_mode, w_mode_in;
    logic [ADDR_W:0]   r_a, w_a_adv;
    logic [2:0]        r_k, w_k_eff, w_k_adv;
    logic [3:0]        r_n, w_n_in;
    logic [DATA_W-1:0] r_prev, r_cur, r_dac, w_prev_n, w_cur_n, w_out;
    logic [ADDR_W-1:0] r_sram_addr;
    logic              r_done, r_fetched, r_lrck, r_finish;
    logic              w_tick, w_fetch_need, w_finish, w_slow;

    assign w_tick = i_daclrck & ~r_lrck;

    // Mode sampled at the tick; N=1 collapses to NORMAL in every mode
    always_comb begin
        w_n_in = {1'b0, i_speed} + 4'd1;
        if (i_speed == 3'd0)  w_mode_in = NORMAL;
        else if (i_fast)      w_mode_in = FAST;
`ifdef AUD_DSP_LINEAR_INTERP_EN
        else if (i_slow_1)    w_mode_in = SLOW1;
`else
        else if (i_slow_1)    w_mode_in = SLOW0;
`endif
        else if (i_slow_0)    w_mode_in = SLOW0;
        else                  w_mode_in = NORMAL;
        w_slow       = (w_mode_in == SLOW0) || (w_mode_in == SLOW1);
        w_k_eff      = (w_mode_in != r_mode) ? 3'd0 : r_k;
        w_fetch_need = !w_slow || (w_k_eff == 3'd0);
    end

    // CALC datapath: capture only applies when this tick fetched
    always_comb begin
        w_prev_n = r_fetched ? r_cur : r_prev;
        w_cur_n  = r_fetched ? sram.rdata : r_cur;
        w_a_adv  = r_a;
        w_k_adv  = r_k;
        case (r_mode)
            NORMAL:  w_a_adv = r_a + 1'b1;
            FAST:    w_a_adv = r_a + (ADDR_W+1)'(r_n);
            default: begin
                // >= rather than == so a k left over from a larger N still wraps
                if ({1'b0, r_k} >= r_n - 4'd1) begin
                    w_k_adv = 3'd0;
                    w_a_adv = r_a + 1'b1;
                end else begin
                    w_k_adv = r_k + 3'd1;
                end
            end
        endcase
    end

`ifdef AUD_DSP_LINEAR_INTERP_EN
    logic [DATA_W-1:0] w_interp;
    aud_interp #(.DATA_W(DATA_W)) u_interp (
        .i_prev (w_prev_n),
        .i_cur  (w_cur_n),
        .i_k    (r_k),
        .i_n    (r_n),
        .o_y    (w_interp)
    );
    assign w_out = (r_mode == SLOW1) ? w_interp : w_cur_n;
`else
    assign w_out = w_cur_n;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_finish = 1'b0;
        o_en     = (r_state == S_WAIT) || (r_state == S_FETCH) || (r_state == S_CALC);
        if (i_stop) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (i_start) w_next = S_WAIT;
                S_WAIT: begin
                    if (i_pause) begin
                        w_next = S_PAUSE;
                    end else if (w_tick) begin
                        if (r_done) begin
                            w_next   = S_IDLE;
                            w_finish = 1'b1;
                        end else begin
                            w_next = w_fetch_need ? S_FETCH : S_CALC;
                        end
                    end
                end
                S_FETCH: w_next = i_pause ? S_PAUSE : S_CALC;
                S_CALC:  w_next = i_pause ? S_PAUSE : S_WAIT;
                S_PAUSE: if (!i_pause && i_start) w_next = S_WAIT;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lrck      <= 1'b0;
            r_finish    <= 1'b0;
            r_a         <= '0;
            r_k         <= '0;
            r_n         <= 4'd1;
            r_mode      <= NORMAL;
            r_prev      <= '0;
            r_cur       <= '0;
            r_done      <= 1'b0;
            r_fetched   <= 1'b0;
            r_dac       <= '0;
            r_sram_addr <= '0;
        end else begin
            r_lrck   <= i_daclrck;
            r_finish <= w_finish;
            case (r_state)
                S_IDLE: if (w_next == S_WAIT) begin
                    r_a    <= '0;
                    r_k    <= '0;
                    r_prev <= '0;
                    r_cur  <= '0;
                    r_done <= 1'b0;
                end
                S_WAIT: if (w_next == S_FETCH || w_next == S_CALC) begin
                    r_mode    <= w_mode_in;
                    r_n       <= w_n_in;
                    r_k       <= w_k_eff;
                    r_fetched <= w_fetch_need;
                    if (w_fetch_need) r_sram_addr <= r_a[ADDR_W-1:0];
                end
                S_CALC: if (w_next == S_WAIT) begin
                    r_prev <= w_prev_n;
                    r_cur  <= w_cur_n;
                    r_dac  <= w_out;
                    r_a    <= w_a_adv;
                    r_k    <= w_k_adv;
                    if (w_a_adv > {1'b0, i_end_addr}) r_done <= 1'b1;
                end
                default: ;
            endcase
            if (w_next == S_IDLE || w_next == S_PAUSE) r_dac <= '0;
        end
    end

    assign sram.addr  = r_sram_addr;
    assign o_dac_data = r_dac;
    assign o_finish   = r_finish;
    assign o_state    = r_state;
endmodule

// File: tb/tb_aud_dsp.sv
// Directed bench for aud_dsp: SRAM model with one-cycle read latency,
// DACLRCK frame of 32 BCLKs, outputs sampled on the falling BCLK edge.
module tb_aud_dsp;
    localparam int AW = 20;
    localparam int DW = 16;

    logic clk = 1'b0, rst = 1'b1, lrck = 1'b0;
    logic start = 1'b0, pause = 1'b0, stop = 1'b0;
    logic fast = 1'b0, slow0 = 1'b0, slow1 = 1'b0;
    logic [2:0]    speed = 3'd0;
    logic [AW-1:0] end_addr = '0;
    logic [DW-1:0] dac;
    logic          en, fin;
    logic [2:0]    st;
    logic [DW-1:0] mem [0:15];
    int n_cmp = 0, n_err = 0, fin_cnt = 0, fetch_cnt = 0, lcnt = 0;

    aud_dsp_if #(.ADDR_W(AW), .DATA_W(DW)) sram_if ();

    aud_dsp #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_pause(pause), .i_stop(stop),
        .i_fast(fast), .i_slow_0(slow0), .i_slow_1(slow1), .i_speed(speed),
        .i_daclrck(lrck), .i_end_addr(end_addr), .sram(sram_if),
        .o_dac_data(dac), .o_en(en), .o_finish(fin), .o_state(st)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        lcnt = lcnt + 1;
        if (lcnt == 16) begin
            lcnt = 0;
            lrck = ~lrck;
        end
    end

    always @(posedge clk) sram_if.rdata <= mem[sram_if.addr[3:0]];

    always @(negedge clk) begin
        if (fin === 1'b1) fin_cnt++;
        if (st == 3'd2) fetch_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no summary, want completion");
        $fatal(1);
    end

    // Returns mid-frame, well after the tick has been fully processed
    task automatic next_frame();
        @(posedge lrck);
        repeat (6) @(negedge clk);
    endtask

    task automatic cmd(input logic s, input logic p, input logic t);
        @(negedge clk);
        start = s; pause = p; stop = t;
        @(negedge clk);
        start = 1'b0; pause = 1'b0; stop = 1'b0;
    endtask

    task automatic set_mode(input logic f, input logic s0, input logic s1,
                            input logic [2:0] sp, input int ea);
        fast = f; slow0 = s0; slow1 = s1; speed = sp; end_addr = AW'(ea);
        for (int i = 0; i < 16; i++) mem[i] = DW'(i);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (dac !== '0) begin n_err++; $display("FAIL reset_dac: got %0d want 0", dac); end
        n_cmp++; if (sram_if.addr !== '0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", sram_if.addr); end
        n_cmp++; if (en !== 1'b0) begin n_err++; $display("FAIL reset_en: got %b want 0", en); end
        n_cmp++; if (fin !== 1'b0) begin n_err++; $display("FAIL reset_finish: got %b want 0", fin); end
        n_cmp++; if (st !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", st); end
        rst = 1'b0;
    endtask

    task automatic test_normal();
        int f0;
        set_mode(1'b0, 1'b0, 1'b0, 3'd0, 3);
        next_frame();
        cmd(1'b1, 1'b0, 1'b0);
        f0 = fin_cnt;
        for (int i = 0; i < 4; i++) begin
            next_frame();
            n_cmp++; if (dac !== DW'(i)) begin n_err++; $display("FAIL normal_out[%0d]: got %0d want %0d", i, $signed(dac), i); end
        end
        n_cmp++; if (fin_cnt != f0) begin n_err++; $display("FAIL normal_early_finish: got %0d pulses want 0", fin_cnt - f0); end
        next_frame();
        n_cmp++; if (fin_cnt != f0 + 1) begin n_err++; $display("FAIL normal_finish: got %0d pulses want 1", fin_cnt - f0); end
        n_cmp++; if (st !== 3'd0) begin n_err++; $display("FAIL normal_idle: got state %0d want 0", st); end
        n_cmp++; if (dac !== '0) begin n_err++; $display("FAIL normal_idle_dac: got %0d want 0", $signed(dac)); end
    endtask

    task automatic test_fast();
        int f0;
        int exp_f [3] = '{0, 3, 6};
        set_mode(1'b1, 1'b0, 1'b0, 3'd2, 7);
        next_frame();
        cmd(1'b1, 1'b0, 1'b0);
        f0 = fin_cnt;
        for (int i = 0; i < 3; i++) begin
            next_frame();
            n_cmp++; if (dac !== DW'(exp_f[i])) begin n_err++; $display("FAIL fast_out[%0d]: got %0d want %0d", i, $signed(dac), exp_f[i]); end
        end
        n_cmp++; if (fin_cnt != f0) begin n_err++; $display("FAIL fast_early_finish: got %0d pulses want 0", fin_cnt - f0); end
        next_frame();
        n_cmp++; if (fin_cnt != f0 + 1) begin n_err++; $display("FAIL fast_finish: got %0d pulses want 1", fin_cnt - f0); end
        n_cmp++; if (st !== 3'd0) begin n_err++; $display("FAIL fast_idle: got state %0d want 0", st); end
    endtask

    task automatic test_slow_hold();
        int f0, c0;
        int exp_h [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
        set_mode(1'b0, 1'b1, 1'b0, 3'd3, 1);
        next_frame();
        cmd(1'b1, 1'b0, 1'b0);
        f0 = fin_cnt;
        c0 = fetch_cnt;
        for (int i = 0; i < 8; i++) begin
            next_frame();
            n_cmp++; if (dac !== DW'(exp_h[i])) begin n_err++; $display("FAIL slow0_out[%0d]: got %0d want %0d", i, $signed(dac), exp_h[i]); end
            if (i == 3) begin
                n_cmp++; if (fetch_cnt - c0 != 1) begin n_err++; $display("FAIL slow0_reads4: got %0d want 1", fetch_cnt - c0); end
            end
        end
        n_cmp++; if (fetch_cnt - c0 != 2) begin n_err++; $display("FAIL slow0_reads8: got %0d want 2", fetch_cnt - c0); end
        next_frame();
        n_cmp++; if (fin_cnt != f0 + 1) begin n_err++; $display("FAIL slow0_finish: got %0d pulses want 1", fin_cnt - f0); end
    endtask

    task automatic test_slow_linear();
        int f0;
        int exp_l [12];
`ifdef AUD_DSP_LINEAR_INTERP_EN
        exp_l = '{0, 0, 0, 0, 0, 25, 50, 75, 100, 50, 0, -50};
`else
        exp_l = '{0, 0, 0, 0, 100, 100, 100, 100, -100, -100, -100, -100};
`endif
        set_mode(1'b0, 1'b0, 1'b1, 3'd3, 2);
        mem[0] = 16'sd0; mem[1] = 16'sd100; mem[2] = -16'sd100;
        next_frame();
        cmd(1'b1, 1'b0, 1'b0);
        f0 = fin_cnt;
        for (int i = 0; i < 12; i++) begin
            next_frame();
            n_cmp++; if (dac !== DW'(exp_l[i])) begin n_err++; $display("FAIL slow1_out[%0d]: got %0d want %0d", i, $signed(dac), exp_l[i]); end
        end
        next_frame();
        n_cmp++; if (fin_cnt != f0 + 1) begin n_err++; $display("FAIL slow1_finish: got %0d pulses want 1", fin_cnt - f0); end
    endtask

    task automatic test_pause();
        int f0;
        set_mode(1'b0, 1'b0, 1'b0, 3'd0, 15);
        next_frame();
        cmd(1'b1, 1'b0, 1'b0);
        f0 = fin_cnt;
        for (int i = 0; i < 5; i++) next_frame();
        n_cmp++; if (dac !== DW'(4)) begin n_err++; $display("FAIL pause_pre: got %0d want 4", $signed(dac)); end
        cmd(1'b0, 1'b1, 1'b0);
        n_cmp++; if (st !== 3'd4) begin n_err++; $display("FAIL pause_state: got %0d want 4", st); end
        for (int i = 0; i < 10; i++) begin
            next_frame();
            n_cmp++; if (dac !== '0 || en !== 1'b0) begin n_err++; $display("FAIL pause_hold[%0d]: got dac %0d en %b want 0 0", i, $signed(dac), en); end
        end
        cmd(1'b1, 1'b0, 1'b0);
        next_frame();
        n_cmp++; if (dac !== DW'(5)) begin n_err++; $display("FAIL pause_resume: got %0d want 5", $signed(dac)); end
        n_cmp++; if (en !== 1'b1) begin n_err++; $display("FAIL pause_resume_en: got %b want 1", en); end
        cmd(1'b0, 1'b1, 1'b1);
        n_cmp++; if (st !== 3'd0 || dac !== '0) begin n_err++; $display("FAIL stop_pause: got state %0d dac %0d want 0 0", st, $signed(dac)); end
        n_cmp++; if (fin_cnt != f0) begin n_err++; $display("FAIL stop_nofinish: got %0d pulses want 0", fin_cnt - f0); end
    endtask

    task automatic test_reset_mid_calc();
        set_mode(1'b0, 1'b0, 1'b0, 3'd0, 15);
        next_frame();
        cmd(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) next_frame();
        n_cmp++; if (dac !== DW'(2)) begin n_err++; $display("FAIL rmid_pre: got %0d want 2", $signed(dac)); end
        @(posedge lrck);
        repeat (2) @(negedge clk);
        n_cmp++; if (st !== 3'd3) begin n_err++; $display("FAIL rmid_in_calc: got state %0d want 3", st); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (dac !== '0 || sram_if.addr !== '0 || en !== 1'b0 || fin !== 1'b0 || st !== 3'd0) begin
            n_err++; $display("FAIL rmid_reset: got dac %0d addr %0d en %b fin %b state %0d want all 0",
                              $signed(dac), sram_if.addr, en, fin, st);
        end
        rst = 1'b0;
        cmd(1'b1, 1'b0, 1'b0);
        next_frame();
        n_cmp++; if (dac !== DW'(0)) begin n_err++; $display("FAIL rmid_replay0: got %0d want 0", $signed(dac)); end
        next_frame();
        n_cmp++; if (dac !== DW'(1) || sram_if.addr !== AW'(1)) begin
            n_err++; $display("FAIL rmid_replay1: got dac %0d addr %0d want 1 1", $signed(dac), sram_if.addr);
        end
        cmd(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = DW'(i);
        test_reset();
        test_normal();
        test_fast();
        test_slow_hold();
        test_slow_linear();
        test_pause();
        test_reset_mid_calc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
